alu_arbiter: RTL

Round-robin arbiter and sequencer sharing one `alu` instance among `NUM_REQ` requesters. Each requester issues an operation (A, B, 3-bit opcode) through a valid/ready handshake. The arbiter grants one requester at a time, drives the ALU operand/control inputs, waits the ALU's registered latency, and returns the result to the winning requester through a per-requester response handshake. It sits between requesting units and the single ALU, and owns the ALU's `A`/`B`/`alu_ctrl` inputs.

---
 rtl/alu_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 29 ++
 rtl/alu_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, datapath width and the
// arbiter sequencer state type.
package alu_pkg;
  localparam int OP_W  = 3;
  localparam int ALU_W = 32;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_AND = 3'b010;
  localparam logic [OP_W-1:0] OP_OR  = 3'b011;
  localparam logic [OP_W-1:0] OP_NOT = 3'b100;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} arb_state_t;

  // Encodings above OP_NOT have no ALU meaning and are answered locally.
  function automatic logic op_legal(input logic [OP_W-1:0] op);
    return op <= OP_NOT;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the search begins one past last_id
// and wraps, so the most recent winner has lowest priority.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_id,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_id,
  output logic          any
);
  always_comb begin
    int idx;
    gnt    = '0;
    gnt_id = '0;
    any    = 1'b0;
    idx    = 0;
    for (int i = 1; i <= N; i++) begin
      idx = int'(last_id) + i;
      if (idx >= N) idx = idx - N;
      if (!any && req[idx]) begin
        any         = 1'b1;
        gnt[idx]    = 1'b1;
        gnt_id      = IW'(idx);
      end
    end
  end
endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered ALU among NUM_REQ requesters: round-robin grant,
// operand launch, latency wait, and a per-requester response handshake.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int ALU_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ*OP_W-1:0]   req_op,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_err,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  output logic [OP_W-1:0]           alu_ctrl,
  input  logic [DATA_W-1:0]         alu_result,
  output logic                      busy
);
  localparam int IW    = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(ALU_LAT + 1);

  arb_state_t          state_q, state_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [IW-1:0]       id_q, id_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [OP_W-1:0]     alu_ctrl_q, alu_ctrl_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_err_q, rsp_err_d;

  logic [NUM_REQ-1:0]  gnt;
  logic [IW-1:0]       gnt_id;
  logic                gnt_any;
  logic [OP_W-1:0]     sel_op;

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
    .req     (req_valid),
    .last_id (ptr_q),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .any     (gnt_any)
  );

  assign sel_op = req_op[int'(gnt_id)*OP_W +: OP_W];

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    id_d       = id_q;
    cnt_d      = cnt_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_ctrl_d = alu_ctrl_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      IDLE: if (gnt_any) begin
        ptr_d = gnt_id;
        id_d  = gnt_id;
        if (op_legal(sel_op)) begin
          alu_a_d    = req_a[int'(gnt_id)*DATA_W +: DATA_W];
          alu_b_d    = req_b[int'(gnt_id)*DATA_W +: DATA_W];
          alu_ctrl_d = sel_op;
          cnt_d      = '0;
          state_d    = EXEC;
        end else begin
          // Illegal op skips the ALU; its operand registers stay untouched.
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = RESP;
        end
      end
      EXEC: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(ALU_LAT)) begin
          rsp_data_d = alu_result;
          rsp_err_d  = 1'b0;
          state_d    = RESP;
        end
      end
      RESP: if (rsp_ready[id_q]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= IW'(NUM_REQ - 1);
      id_q       <= '0;
      cnt_q      <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_ctrl_q <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      id_q       <= id_d;
      cnt_q      <= cnt_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_ctrl_q <= alu_ctrl_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (state_q == RESP) rsp_valid[id_q] = 1'b1;
  end

  assign req_ready = (state_q == IDLE && !rst) ? gnt : '0;
  assign busy      = (state_q != IDLE);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_ctrl  = alu_ctrl_q;
endmodule
